// File: rtl/mc_rfr_ctrl_if.sv
// Refresh handshake between the refresh scheduler and the main controller FSM.
//   rfr_req     : refresh request from the scheduler
//   rfr_ack     : one-cycle acknowledge from the main FSM (refresh command issued)
//   cs_need_rfr : per-chip-select refresh mask, valid while rfr_req and in the ack cycle
//   rfr_pend    : current backlog of owed refreshes
//   rfr_ovf     : one-cycle pulse when a due refresh was lost to saturation
// Modports: master = scheduler (mc_rfr_ctrl), slave = main controller FSM.
interface mc_rfr_ctrl_if;
  logic       rfr_req;
  logic       rfr_ack;
  logic [7:0] cs_need_rfr;
  logic [2:0] rfr_pend;
  logic       rfr_ovf;

  modport master (
    output rfr_req,
    output cs_need_rfr,
    output rfr_pend,
    output rfr_ovf,
    input  rfr_ack
  );

  modport slave (
    input  rfr_req,
    input  cs_need_rfr,
    input  rfr_pend,
    input  rfr_ovf,
    output rfr_ack
  );
endinterface

// File: rtl/mc_rfr_ctrl.sv
// SDRAM refresh scheduler on the memory clock.
// A prescaler and an interval counter divide mc_clk into a refresh period of
// (rfr_ps_val+1) * 2^rfr_int cycles. Each period end adds one owed refresh to a
// saturating backlog; a request/acknowledge handshake with the main FSM drains it.
//
// Ports:
//   mc_clk      : memory clock, all state on the rising edge
//   rst         : asynchronous active-high reset
//   cs_rfr_en   : static mask of chip selects that need refresh (0 disables refresh)
//   rfr_ps_val  : prescaler terminal count
//   rfr_int     : interval select, one refresh every 2^rfr_int prescaler ticks
//   init_rfr    : one-cycle pulse from the init sequence, adds init refreshes
//   suspended_o : controller in suspend/self-refresh; counters hold, backlog cleared
//   rfr_if      : handshake interface (master side)
//
// Build option: define MC_RFR_BURST_EN for a multi-entry backlog saturating at
// MAX_PEND with init_rfr adding INIT_CNT. Without it the backlog is a single bit
// and init_rfr adds one refresh.
module mc_rfr_ctrl #(
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned INIT_CNT = 2
) (
  input  logic                 mc_clk,
  input  logic                 rst,
  input  logic [7:0]           cs_rfr_en,
  input  logic [7:0]           rfr_ps_val,
  input  logic [2:0]           rfr_int,
  input  logic                 init_rfr,
  input  logic                 suspended_o,
  mc_rfr_ctrl_if.master        rfr_if
);

`ifdef MC_RFR_BURST_EN
  localparam int unsigned PendW   = 3;
  localparam int unsigned PendMax = MAX_PEND;
  localparam int unsigned IncInit = INIT_CNT;
`else
  localparam int unsigned PendW   = 1;
  localparam int unsigned PendMax = 1;
  localparam int unsigned IncInit = 1;
`endif

  if (MAX_PEND == 0 || MAX_PEND > 7) begin : g_bad_max_pend
    $error("mc_rfr_ctrl: MAX_PEND must be in 1..7");
  end
  if (INIT_CNT > 7) begin : g_bad_init_cnt
    $error("mc_rfr_ctrl: INIT_CNT must be in 0..7");
  end

  typedef enum logic {StIdle, StReq} state_e;

  state_e           state_q, state_d;
  logic [7:0]       ps_cnt_q, ps_cnt_d;
  logic [7:0]       int_cnt_q, int_cnt_d;
  logic [PendW-1:0] pend_q, pend_d;
  logic [7:0]       cs_need_q, cs_need_d;
  logic             ovf_q, ovf_d;

  logic       tick;
  logic       due;
  logic [7:0] int_term;
  logic       rfr_active;
  logic       ack_taken;
  logic [3:0] pend_sum;
  logic [3:0] pend_net;

  assign rfr_active = (cs_rfr_en != 8'h00);
  // An ack only counts while a request is outstanding and not being dropped by suspend.
  assign ack_taken  = (state_q == StReq) && rfr_if.rfr_ack && !suspended_o;

  // Prescaler and interval counter; both freeze while suspended.
  always_comb begin
    ps_cnt_d  = ps_cnt_q;
    int_cnt_d = int_cnt_q;
    tick      = 1'b0;
    due       = 1'b0;
    int_term  = (8'd1 << rfr_int) - 8'd1;
    if (!suspended_o) begin
      // >= so a shrinking terminal count never strands the counter above it.
      if (ps_cnt_q >= rfr_ps_val) begin
        tick     = 1'b1;
        ps_cnt_d = 8'd0;
      end else begin
        ps_cnt_d = ps_cnt_q + 8'd1;
      end
      if (tick) begin
        if (int_cnt_q >= int_term) begin
          due       = 1'b1;
          int_cnt_d = 8'd0;
        end else begin
          int_cnt_d = int_cnt_q + 8'd1;
        end
      end
    end
  end

  // Backlog: add due/init, remove an accepted ack, saturate and flag lost increments.
  always_comb begin
    pend_sum = 4'(pend_q) + {3'b000, due} + (init_rfr ? 4'(IncInit) : 4'd0);
    pend_net = (ack_taken && (pend_sum != 4'd0)) ? pend_sum - 4'd1 : pend_sum;
    pend_d   = pend_q;
    ovf_d    = 1'b0;
    if (suspended_o || !rfr_active) begin
      pend_d = '0;
    end else if (pend_net > 4'(PendMax)) begin
      pend_d = PendW'(PendMax);
      ovf_d  = 1'b1;
    end else begin
      pend_d = PendW'(pend_net);
    end
  end

  // Handshake FSM; decisions use the registered backlog.
  always_comb begin
    state_d   = state_q;
    cs_need_d = cs_need_q;
    unique case (state_q)
      StIdle: begin
        if ((pend_q != '0) && rfr_active && !suspended_o) begin
          state_d   = StReq;
          cs_need_d = cs_rfr_en;
        end
      end
      StReq: begin
        if (suspended_o || rfr_if.rfr_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mc_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ps_cnt_q  <= 8'd0;
      int_cnt_q <= 8'd0;
      pend_q    <= '0;
      cs_need_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_cnt_q  <= ps_cnt_d;
      int_cnt_q <= int_cnt_d;
      pend_q    <= pend_d;
      cs_need_q <= cs_need_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rfr_if.rfr_req     = (state_q == StReq);
  assign rfr_if.cs_need_rfr = cs_need_q;
  assign rfr_if.rfr_pend    = 3'(pend_q);
  assign rfr_if.rfr_ovf     = ovf_q;

endmodule

// File: tb/tb_mc_rfr_ctrl.sv
// Scoreboard bench for mc_rfr_ctrl: directed scenarios push expected request
// rises and overflow pulses into queues; a negedge monitor pops and compares.
// Cycle numbering: cycle 0 is the cycle in which reset is released.
module tb_mc_rfr_ctrl;

  logic       mc_clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cs_rfr_en = 8'h03;
  logic [7:0] rfr_ps_val = 8'd3;
  logic [2:0] rfr_int = 3'd2;
  logic       init_rfr = 1'b0;
  logic       suspended_o = 1'b0;

  mc_rfr_ctrl_if rif ();

  mc_rfr_ctrl #(
    .MAX_PEND (4),
    .INIT_CNT (2)
  ) dut (
    .mc_clk      (mc_clk),
    .rst         (rst),
    .cs_rfr_en   (cs_rfr_en),
    .rfr_ps_val  (rfr_ps_val),
    .rfr_int     (rfr_int),
    .init_rfr    (init_rfr),
    .suspended_o (suspended_o),
    .rfr_if      (rif)
  );

  always #5 mc_clk = ~mc_clk;

  int cyc = 0;
  always @(posedge mc_clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [7:0] mask;
    logic [2:0] pend;
  } req_exp_t;

  req_exp_t req_q[$];
  int       ovf_q[$];
  int       n_checks = 0;
  int       n_fail = 0;

  bit auto_ack = 1'b0;
  bit force_ack = 1'b0;
  int ack_lag = 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_req(input int c, input logic [7:0] m, input logic [2:0] p);
    req_exp_t e;
    e.cyc  = c;
    e.mask = m;
    e.pend = p;
    req_q.push_back(e);
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge mc_clk);
      #1;
    end
  endtask

  task automatic drain_check();
    check("req_queue_empty", req_q.size(), 0);
    check("ovf_queue_empty", ovf_q.size(), 0);
    req_q.delete();
    ovf_q.delete();
  endtask

  task automatic do_reset();
    @(negedge mc_clk);
    rst         = 1'b1;
    init_rfr    = 1'b0;
    suspended_o = 1'b0;
    force_ack   = 1'b0;
    auto_ack    = 1'b0;
    repeat (2) @(posedge mc_clk);
    @(negedge mc_clk);
    rst = 1'b0;
  endtask

  // Monitor: every request rise and every overflow pulse must match the head of its queue.
  initial begin
    req_exp_t e;
    logic     req_seen;
    int       oc;
    req_seen = 1'b0;
    forever begin
      @(negedge mc_clk);
      if (rif.rfr_req === 1'b1 && !req_seen) begin
        if (req_q.size() == 0) begin
          check("unexpected_req_cycle", cyc, -1);
        end else begin
          e = req_q.pop_front();
          check("req_rise_cycle", cyc, e.cyc);
          check("req_mask", int'(rif.cs_need_rfr), int'(e.mask));
          check("req_pend", int'(rif.rfr_pend), int'(e.pend));
        end
      end
      if (rif.rfr_ovf === 1'b1) begin
        if (ovf_q.size() == 0) begin
          check("unexpected_ovf_cycle", cyc, -1);
        end else begin
          oc = ovf_q.pop_front();
          check("ovf_cycle", cyc, oc);
        end
      end
      req_seen = (rif.rfr_req === 1'b1);
    end
  end

  // Ack responder: lag 0 acks in the rise cycle, lag 1 the cycle after.
  initial begin
    logic ack_prev;
    ack_prev    = 1'b0;
    rif.rfr_ack = 1'b0;
    forever begin
      @(negedge mc_clk);
      if (force_ack) begin
        rif.rfr_ack = 1'b1;
      end else if (auto_ack && rif.rfr_req === 1'b1 && !rif.rfr_ack &&
                   (ack_lag == 0 || ack_prev)) begin
        rif.rfr_ack = 1'b1;
      end else begin
        rif.rfr_ack = 1'b0;
      end
      ack_prev = (rif.rfr_req === 1'b1);
    end
  end

  initial begin
    // Basic period: due at 15, 31, 47 -> requests at 17, 33, 49.
    cs_rfr_en = 8'h03; rfr_ps_val = 8'd3; rfr_int = 3'd2;
    do_reset();
    check("rst_req", int'(rif.rfr_req), 0);
    check("rst_mask", int'(rif.cs_need_rfr), 0);
    check("rst_pend", int'(rif.rfr_pend), 0);
    check("rst_ovf", int'(rif.rfr_ovf), 0);
    auto_ack = 1'b1; ack_lag = 1;
    exp_req(17, 8'h03, 3'd1);
    exp_req(33, 8'h03, 3'd1);
    exp_req(49, 8'h03, 3'd1);
    at_cycle(16);
    check("basic_pend_after_due", int'(rif.rfr_pend), 1);
    check("basic_req_not_yet", int'(rif.rfr_req), 0);
    at_cycle(19);
    check("basic_req_low_after_ack", int'(rif.rfr_req), 0);
    check("basic_pend_after_ack", int'(rif.rfr_pend), 0);
    at_cycle(56);
    drain_check();

    // Backlog: no acks until cycle 100, then immediate acks.
    do_reset();
    exp_req(17, 8'h03, 3'd1);
`ifdef MC_RFR_BURST_EN
    exp_req(102, 8'h03, 3'd3);
    exp_req(104, 8'h03, 3'd2);
    exp_req(106, 8'h03, 3'd1);
    ovf_q.push_back(80);
    ovf_q.push_back(96);
`else
    ovf_q.push_back(32);
    ovf_q.push_back(48);
    ovf_q.push_back(64);
    ovf_q.push_back(80);
    ovf_q.push_back(96);
`endif
    at_cycle(100);
`ifdef MC_RFR_BURST_EN
    check("backlog_pend_sat", int'(rif.rfr_pend), 4);
`else
    check("backlog_pend_sat", int'(rif.rfr_pend), 1);
`endif
    auto_ack = 1'b1; ack_lag = 0;
    at_cycle(109);
    check("backlog_pend_drained", int'(rif.rfr_pend), 0);
    check("backlog_req_idle", int'(rif.rfr_req), 0);
    drain_check();

    // Init pulse with the counters effectively idle.
    rfr_ps_val = 8'd255; rfr_int = 3'd7;
    do_reset();
    auto_ack = 1'b1; ack_lag = 1;
`ifdef MC_RFR_BURST_EN
    exp_req(4, 8'h03, 3'd2);
    exp_req(7, 8'h03, 3'd1);
`else
    exp_req(4, 8'h03, 3'd1);
`endif
    at_cycle(2);
    init_rfr = 1'b1;
    at_cycle(3);
    init_rfr = 1'b0;
`ifdef MC_RFR_BURST_EN
    check("init_pend", int'(rif.rfr_pend), 2);
`else
    check("init_pend", int'(rif.rfr_pend), 1);
`endif
    at_cycle(12);
    check("init_pend_done", int'(rif.rfr_pend), 0);
    check("init_req_done", int'(rif.rfr_req), 0);
    drain_check();

    // Suspend during a request; ps=2/int=0 held for cycles 50..59 delays the next due to 73.
    rfr_ps_val = 8'd3; rfr_int = 3'd2;
    do_reset();
    exp_req(17, 8'h03, 3'd1);
    exp_req(75, 8'h03, 3'd1);
`ifndef MC_RFR_BURST_EN
    ovf_q.push_back(32);
    ovf_q.push_back(48);
`endif
    at_cycle(49);
`ifdef MC_RFR_BURST_EN
    check("susp_pend_before", int'(rif.rfr_pend), 3);
`else
    check("susp_pend_before", int'(rif.rfr_pend), 1);
`endif
    at_cycle(50);
    suspended_o = 1'b1;
    force_ack   = 1'b1;
    at_cycle(51);
    force_ack = 1'b0;
    check("susp_req_dropped", int'(rif.rfr_req), 0);
    check("susp_pend_cleared", int'(rif.rfr_pend), 0);
    at_cycle(60);
    suspended_o = 1'b0;
    at_cycle(73);
    check("susp_pend_before_due", int'(rif.rfr_pend), 0);
    at_cycle(74);
    check("susp_pend_after_due", int'(rif.rfr_pend), 1);
    at_cycle(78);
    drain_check();

    // Coincident due and ack with pend=1.
    do_reset();
    exp_req(17, 8'h03, 3'd1);
    exp_req(33, 8'h03, 3'd1);
    at_cycle(31);
    force_ack = 1'b1;
    at_cycle(32);
    force_ack = 1'b0;
    check("coinc_pend_kept", int'(rif.rfr_pend), 1);
    check("coinc_req_low", int'(rif.rfr_req), 0);
    at_cycle(40);
    drain_check();

    // Refresh disabled: no requests, init ignored.
    cs_rfr_en = 8'h00;
    do_reset();
    auto_ack = 1'b1; ack_lag = 1;
    at_cycle(5);
    init_rfr = 1'b1;
    at_cycle(6);
    init_rfr = 1'b0;
    check("mask0_pend_init", int'(rif.rfr_pend), 0);
    at_cycle(40);
    check("mask0_pend", int'(rif.rfr_pend), 0);
    check("mask0_req", int'(rif.rfr_req), 0);
    drain_check();

    // Asynchronous reset mid-request.
    cs_rfr_en = 8'h81;
    do_reset();
    exp_req(17, 8'h81, 3'd1);
    at_cycle(18);
    check("areset_req_before", int'(rif.rfr_req), 1);
    check("areset_mask_before", int'(rif.cs_need_rfr), 8'h81);
    #2;
    rst = 1'b1;
    #1;
    check("areset_req", int'(rif.rfr_req), 0);
    check("areset_mask", int'(rif.cs_need_rfr), 0);
    check("areset_pend", int'(rif.rfr_pend), 0);
    drain_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
